// File: rtl/serial_parity_rx.sv
// Serial-to-parallel frame receiver: DATA_W data bits plus one trailing parity bit,
// odd/even parity check, valid/ready word output and a saturating failed-frame counter.
module serial_parity_rx #(
  parameter int DATA_W    = 32,
  parameter bit LSB_FIRST = 1'b1,
  parameter int ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              par_mode,
  input  logic              frame_clr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_mode,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              par_ok,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count, count_inc;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              xor_q;
  logic              mode_q;
  logic              accept;
  logic              frame_done;
  logic              ok_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; frame_clr overrides any bit presented the same cycle
  always_comb begin
    state_nxt = state;
    if (frame_clr) begin
      state_nxt = IDLE;
    end else if (accept) begin
      unique case (state)
        IDLE:    state_nxt = DATA;
        DATA:    if (count_inc == CNT_W'(DATA_W)) state_nxt = PAR;
        PAR:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    din_ready  = !(dout_valid && !dout_ready);
    accept     = din_valid && din_ready;
    frame_done = accept && !frame_clr && (state == PAR);
    ok_nxt     = mode_q ? (xor_q ^ din) : !(xor_q ^ din);
  end

  // Each data bit is written straight to its final position instead of shifting
  always_comb begin : bit_place
    int unsigned pos;
    count_inc = count + CNT_W'(1);
    shreg_nxt = shreg;
    pos = LSB_FIRST ? 32'(count) : 32'(DATA_W - 1) - 32'(count);
    for (int unsigned i = 0; i < 32'(DATA_W); i++) begin
      if (i == pos) shreg_nxt[i] = din;
    end
  end

  // Frame assembly datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      shreg  <= '0;
      xor_q  <= 1'b0;
      mode_q <= 1'b0;
    end else if (frame_clr) begin
      count <= '0;
      shreg <= '0;
      xor_q <= 1'b0;
    end else if (accept) begin
      if (state == PAR) begin
        count <= '0;
        xor_q <= 1'b0;
      end else begin
        count <= count_inc;
        xor_q <= xor_q ^ din;
        shreg <= shreg_nxt;
      end
      if (state == IDLE) mode_q <= par_mode;
    end
  end

  // Output word, handshake and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_mode  <= 1'b0;
      dout_valid <= 1'b0;
      par_ok     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (frame_done) begin
        dout       <= shreg;
        dout_mode  <= mode_q;
        par_ok     <= ok_nxt;
        dout_valid <= 1'b1;
        if (!ok_nxt && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Randomised bench for serial_parity_rx: frames are built from whole data words and
// checked against a word-level parity/popcount reference and an expected-word queue.
module tb_serial_parity_rx;

  localparam int DATA_W = 32;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              din;
  logic              din_valid;
  logic              din_ready;
  logic              par_mode;
  logic              frame_clr;
  logic [DATA_W-1:0] dout;
  logic              dout_mode;
  logic              dout_valid;
  logic              dout_ready;
  logic              par_ok;
  logic [ERR_W-1:0]  err_cnt;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              mode;
    logic              ok;
  } exp_t;

  exp_t q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   err_model  = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
  bit   gap_en     = 1'b0;

  serial_parity_rx #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(1'b1),
    .ERR_W    (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .par_mode  (par_mode),
    .frame_clr (frame_clr),
    .dout      (dout),
    .dout_mode (dout_mode),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .par_ok    (par_ok),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Consumer: drives dout_ready just after each rising edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
  end

  // Monitor: output word must match the oldest expected frame while valid
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("din_ready_rule", din_ready, !(dout_valid && !dout_ready));
      if (dout_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", dout_valid, 1'b0);
        end else begin
          check("dout", dout, q[0].data);
          check("dout_mode", dout_mode, q[0].mode);
          check("par_ok", par_ok, q[0].ok);
          if (dout_ready) void'(q.pop_front());
        end
      end
    end
  end

  // Presents one bit and returns #1 after the edge that accepted it
  task automatic send_bit(input logic b);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        din_valid = 1'b0;
        din       = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    din       = b;
    din_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
      n++;
      if (n > 500) begin
        $display("FAIL send_bit_timeout: got din_ready=0 for %0d cycles expected 1", n);
        $fatal(1, "bit never accepted");
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input logic mode, input logic par);
    bit odd;
    bit ok;
    par_mode = mode;
    for (int k = 0; k < DATA_W; k++) begin
      send_bit(data[k]);
      par_mode = 1'($urandom);
    end
    send_bit(par);
    odd = ((int'($countones(data)) + int'(par)) % 2) == 1;
    ok  = mode ? odd : !odd;
    q.push_back('{data: data, mode: mode, ok: ok});
    if (!ok && err_model < (2 ** ERR_W) - 1) err_model++;
    @(negedge clk);
    check("latency_valid", dout_valid, 1'b1);
    check("err_cnt", err_cnt, 64'(err_model));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    par_mode   = 1'b0;
    frame_clr  = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, '0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout_mode", dout_mode, 1'b0);
    check("rst_par_ok", par_ok, 1'b0);
    check("rst_err_cnt", err_cnt, '0);
    check("rst_din_ready", din_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed odd pass / even fail / even pass
    send_frame(32'h0000_0001, 1'b1, 1'b0);
    send_frame(32'h0000_0001, 1'b0, 1'b0);
    send_frame(32'h0000_0001, 1'b0, 1'b1);

    // Backpressure: word held while consumer stalls, next frame waits
    ready_mode = 2;
    send_frame(32'hA5A5_A5A5, 1'b1, 1'b0);
    fork
      send_frame(32'h1234_5678, 1'b0, 1'b1);
      begin
        repeat (15) @(posedge clk);
        ready_mode = 0;
      end
    join

    // Gap then frame_clr abort, followed by a clean all-ones frame
    for (int k = 0; k < 10; k++) send_bit(1'($urandom));
    repeat (5) @(posedge clk);
    #1;
    frame_clr = 1'b1;
    din       = 1'b1;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_clr = 1'b0;
    din_valid = 1'b0;
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b1);

    // frame_clr on the parity-bit edge suppresses the output load
    par_mode = 1'b1;
    for (int k = 0; k < DATA_W; k++) send_bit(1'b0);
    frame_clr = 1'b1;
    din       = 1'b0;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_clr = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    check("clr_wins_valid", dout_valid, 1'b0);
    check("clr_wins_err", err_cnt, 64'(err_model));
    @(posedge clk);
    #1;
    send_frame(32'hDEAD_BEEF, 1'b1, 1'b1);

    // Random frames with random input gaps and random consumer stalls
    ready_mode = 1;
    gap_en     = 1'b1;
    repeat (80) send_frame($urandom, 1'($urandom), 1'($urandom));
    gap_en     = 1'b0;
    ready_mode = 0;

    // Counter saturation
    repeat (260) send_frame(32'h0, 1'b1, 1'b0);
    check("err_saturated", err_cnt, 64'((2 ** ERR_W) - 1));

    // Reset with a word pending and input stalled
    ready_mode = 2;
    send_frame($urandom, 1'($urandom), 1'($urandom));
    din       = 1'b1;
    din_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    err_model = 0;
    #1;
    check("rst_pend_valid", dout_valid, 1'b0);
    check("rst_pend_err", err_cnt, '0);
    check("rst_pend_ready", din_ready, 1'b1);
    din_valid  = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset at bit 17 of a partial frame
    for (int k = 0; k < 17; k++) send_bit(1'($urandom));
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", dout_valid, 1'b0);
    check("rst_mid_ready", din_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(32'hC0FF_EE01, 1'b1, 1'b0);
    send_frame($urandom, 1'($urandom), 1'($urandom));

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
